// File: rtl/cpu_pkg.sv
// Shared definitions for the 9-bit CPU fetch path.
//   fetch_state_t : sequencer states (IDLE, RUN, DONE)
//   PW_DEFAULT    : default program-counter width
//   TARG_SEL_W    : width of the branch-offset LUT index
package cpu_pkg;

  localparam int unsigned PW_DEFAULT = 10;
  localparam int unsigned TARG_SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/lut_targets.sv
// Branch-offset lookup table: maps the decoder's TargSel index to a signed
// PW-bit two's-complement PC offset.
//   targ_sel_i : LUT index from the control decoder
//   offset_o   : selected offset, returned as raw PW-bit pattern
module lut_targets
  import cpu_pkg::*;
#(
  parameter int unsigned        PW = PW_DEFAULT,
  parameter logic signed [PW-1:0] T0 = PW'(3),
  parameter logic signed [PW-1:0] T1 = PW'(-4),
  parameter logic signed [PW-1:0] T2 = PW'(8),
  parameter logic signed [PW-1:0] T3 = PW'(-16)
) (
  input  logic [TARG_SEL_W-1:0] targ_sel_i,
  output logic [PW-1:0]         offset_o
);

  always_comb begin
    offset_o = T0;
    unique case (targ_sel_i)
      2'd0:    offset_o = T0;
      2'd1:    offset_o = T1;
      2'd2:    offset_o = T2;
      2'd3:    offset_o = T3;
      default: offset_o = T0;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Program-counter and instruction-fetch sequencer. Owns the Start/Done run
// handshake and chooses the next instruction address from the decoder's
// Jump/BranchEn/TargSel/Ack outputs.
//   Clk, Reset          : clock and synchronous active-high reset
//   Start               : level, begin or restart the program
//   Hold                : freeze the sequencer this cycle while in RUN
//   Jump, BranchEn      : taken transfer requests (branch gated by CondFlag)
//   CondFlag            : ALU condition for BranchEn
//   TargSel             : branch-offset LUT index
//   Ack                 : program-complete instruction
//   ProgCtr             : registered instruction address
//   Done                : registered program-finished flag
//   Running             : high while in RUN
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned          PW = PW_DEFAULT,
  parameter logic signed [PW-1:0] T0 = PW'(3),
  parameter logic signed [PW-1:0] T1 = PW'(-4),
  parameter logic signed [PW-1:0] T2 = PW'(8),
  parameter logic signed [PW-1:0] T3 = PW'(-16)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  Hold,
  input  logic                  Jump,
  input  logic                  BranchEn,
  input  logic                  CondFlag,
  input  logic [TARG_SEL_W-1:0] TargSel,
  input  logic                  Ack,
  output logic [PW-1:0]         ProgCtr,
  output logic                  Done,
  output logic                  Running
);

  fetch_state_t  state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic          done_q, done_d;
  logic [PW-1:0] offset;
  logic          taken;

  lut_targets #(
    .PW (PW),
    .T0 (T0),
    .T1 (T1),
    .T2 (T2),
    .T3 (T3)
  ) u_lut_targets (
    .targ_sel_i (TargSel),
    .offset_o   (offset)
  );

  assign taken = Jump | (BranchEn & CondFlag);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      IDLE: begin
        pc_d = '0;
        if (Start) state_d = RUN;
      end
      RUN: begin
        if (!Hold) begin
          // Ack is checked first: the all-ones Ack opcode also raises Jump/BranchEn.
          if (Ack) begin
            state_d = DONE;
          end else if (taken) begin
            // Offset is two's complement, so a plain PW-bit add wraps correctly.
            pc_d = pc_q + offset;
          end else begin
            pc_d = pc_q + PW'(1);
          end
        end
      end
      DONE: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
      end
    endcase
    done_d = (state_d == DONE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
    end
  end

  assign ProgCtr = pc_q;
  assign Done    = done_q;
  assign Running = (state_q == RUN);

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam int PW  = 10;
  localparam int MOD = 1 << PW;

  logic          clk;
  logic          reset, start, hold, jump, branch_en, cond_flag, ack;
  logic [1:0]    targ_sel;
  logic [PW-1:0] prog_ctr;
  logic          done, running;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: 0 = idle, 1 = run, 2 = done
  int m_st = 0;
  int m_pc = 0;
  int offs [4] = '{3, -4, 8, -16};

  instr_fetch dut (
    .Clk      (clk),
    .Reset    (reset),
    .Start    (start),
    .Hold     (hold),
    .Jump     (jump),
    .BranchEn (branch_en),
    .CondFlag (cond_flag),
    .TargSel  (targ_sel),
    .Ack      (ack),
    .ProgCtr  (prog_ctr),
    .Done     (done),
    .Running  (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic h, input logic j,
                       input logic be, input logic cf, input logic [1:0] ts,
                       input logic a);
    reset = r; start = s; hold = h; jump = j;
    branch_en = be; cond_flag = cf; targ_sel = ts; ack = a;
  endtask

  task automatic model_step();
    if (reset) begin
      m_st = 0; m_pc = 0;
    end else if (m_st == 0) begin
      if (start) begin m_st = 1; m_pc = 0; end
    end else if (m_st == 1) begin
      if (hold) begin
      end else if (ack) begin
        m_st = 2;
      end else if (jump || (branch_en && cond_flag)) begin
        m_pc = (((m_pc + offs[targ_sel]) % MOD) + MOD) % MOD;
      end else begin
        m_pc = (m_pc + 1) % MOD;
      end
    end else begin
      if (start) begin m_st = 1; m_pc = 0; end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("pc", int'(prog_ctr), m_pc);
    check("running", int'(running), int'(m_st == 1));
    check("done", int'(done), int'(m_st == 2));
  endtask

  task automatic restart();
    drive(1, 0, 0, 0, 0, 0, 2'd0, 0); tick();
    drive(0, 1, 0, 0, 0, 0, 2'd0, 0); tick();
    check("start_pc", int'(prog_ctr), 0);
    check("start_running", int'(running), 1);
  endtask

  task automatic goto_pc(input int target);
    for (int i = 0; i < 2 * MOD && m_pc != target; i++) begin
      drive(0, 0, 0, 0, 0, 0, 2'd0, 0);
      tick();
    end
    check("goto", int'(prog_ctr), target);
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 2'd0, 0);
    // Reset for two cycles, then an idle cycle with no Start
    tick(); check("rst_pc", int'(prog_ctr), 0);
    tick(); check("rst_done", int'(done), 0);
    drive(0, 0, 0, 1, 1, 1, 2'd2, 1); tick();
    check("idle_pc", int'(prog_ctr), 0);
    check("idle_running", int'(running), 0);

    drive(0, 1, 0, 0, 0, 0, 2'd0, 0); tick();
    check("start_pc0", int'(prog_ctr), 0);
    drive(0, 0, 0, 0, 0, 0, 2'd0, 0);
    tick(); check("seq_pc1", int'(prog_ctr), 1);
    tick(); check("seq_pc2", int'(prog_ctr), 2);
    tick(); check("seq_pc3", int'(prog_ctr), 3);

    // Taken transfers from PC=5
    goto_pc(5);
    drive(0, 0, 0, 1, 0, 0, 2'd1, 0); tick();
    check("jump_t1", int'(prog_ctr), 1);
    restart(); goto_pc(5);
    drive(0, 0, 0, 0, 1, 1, 2'd2, 0); tick();
    check("branch_t2", int'(prog_ctr), 13);
    restart(); goto_pc(5);
    drive(0, 0, 0, 0, 1, 0, 2'd2, 0); tick();
    check("branch_nt", int'(prog_ctr), 6);

    // Wrap: 0 - 16 = 1008, walk to 1023, then increment to 0
    restart();
    drive(0, 0, 0, 1, 0, 0, 2'd3, 0); tick();
    check("wrap_neg0", int'(prog_ctr), 1008);
    goto_pc(1023);
    drive(0, 0, 0, 0, 0, 0, 2'd0, 0); tick();
    check("wrap_inc", int'(prog_ctr), 0);
    goto_pc(2);
    drive(0, 0, 0, 1, 0, 0, 2'd3, 0); tick();
    check("wrap_neg2", int'(prog_ctr), 1010);

    // Ack beats Jump/BranchEn
    restart(); goto_pc(7);
    drive(0, 0, 0, 1, 1, 1, 2'd3, 1); tick();
    check("ack_pc", int'(prog_ctr), 7);
    check("ack_done", int'(done), 1);
    drive(0, 0, 0, 0, 0, 0, 2'd0, 0); tick();
    check("done_hold", int'(done), 1);
    drive(0, 1, 0, 0, 0, 0, 2'd0, 0); tick();
    check("restart_pc", int'(prog_ctr), 0);
    check("restart_done", int'(done), 0);

    // Hold with Ack asserted
    goto_pc(4);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 0, 0, 2'd0, 1); tick();
      check("hold_pc", int'(prog_ctr), 4);
      check("hold_done", int'(done), 0);
    end
    drive(0, 0, 0, 0, 0, 0, 2'd0, 0); tick();
    check("hold_release", int'(prog_ctr), 5);

    // Reset mid-RUN wins over Start
    goto_pc(9);
    drive(1, 1, 0, 0, 0, 0, 2'd0, 0); tick();
    check("rst_run_pc", int'(prog_ctr), 0);
    check("rst_run_running", int'(running), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(63) == 0), ($urandom_range(7) == 0),
            (m_st == 1) && ($urandom_range(5) == 0), ($urandom_range(5) == 0),
            ($urandom_range(3) == 0), 1'($urandom), 2'($urandom),
            ($urandom_range(19) == 0));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
